// File: rtl/dram_arbiter.sv
// Round-robin arbiter/sequencer sharing one block-wide DRAM port between NUM_REQ requesters.
// Latency: accept T, mem_valid T+1, mem_ready sampled from T+2, resp_valid T+3 (or timeout).
// Backpressure: one transaction outstanding; req_ready pulses only in IDLE; DRAM stalls are bounded by TIMEOUT.
module dram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*32-1:0]    req_addr,
    input  logic [NUM_REQ*128-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [127:0]             resp_rdata,
    output logic                     mem_valid,
    output logic                     mem_write,
    output logic [31:0]              mem_adr,
    output logic [127:0]             mem_wdata,
    input  logic [127:0]             mem_rdata,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, r_gnt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_mem_write, r_timeout_err;
    logic [31:0]     r_mem_adr;
    logic [127:0]    r_mem_wdata, r_resp_rdata;

    logic            w_any, w_accept, w_load_rd, w_clr_rd, w_set_err;
    logic [PW-1:0]   w_gnt, w_ptr_nxt;
    logic            w_sel_write;
    logic [31:0]     w_sel_addr;
    logic [127:0]    w_sel_wdata;
    int              w_k;

    // First pending requester at or after rr_ptr, wrapping
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_k   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_any && req_valid[w_k]) begin
                w_any = 1'b1;
                w_gnt = PW'(w_k);
            end
        end
    end

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == w_gnt) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[32*i +: 32];
                w_sel_wdata = req_wdata[128*i +: 128];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == LAST_REQ) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rst_n gating keeps req_ready at zero while the block is held in reset
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_load_rd   = 1'b0;
        w_clr_rd    = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && rst_n) begin
                    req_ready[w_gnt] = 1'b1;
                    w_accept         = 1'b1;
                    w_state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    w_load_rd   = !r_mem_write;
                    w_state_nxt = RESP;
                end else if (r_cnt == CNT_MAX) begin
                    w_set_err   = 1'b1;
                    w_clr_rd    = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_gnt         <= '0;
            r_cnt         <= '0;
            r_mem_write   <= 1'b0;
            r_mem_adr     <= '0;
            r_mem_wdata   <= '0;
            r_resp_rdata  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_gnt       <= w_gnt;
                r_rr_ptr    <= w_ptr_nxt;
                r_mem_write <= w_sel_write;
                r_mem_adr   <= w_sel_addr & ~32'h3;
                r_mem_wdata <= w_sel_wdata;
            end
            if (w_load_rd) begin
                r_resp_rdata <= mem_rdata;
            end else if (w_clr_rd) begin
                r_resp_rdata <= '0;
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Strobes decode straight from state so reset drops them asynchronously
    assign mem_valid   = (r_state == ISSUE);
    assign busy        = (r_state != IDLE);
    assign resp_valid  = (r_state == RESP) ? (NUM_REQ'(1) << r_gnt) : '0;
    assign resp_rdata  = r_resp_rdata;
    assign mem_write   = r_mem_write;
    assign mem_adr     = r_mem_adr;
    assign mem_wdata   = r_mem_wdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: vector table of single transactions plus
// hand-written round-robin, timeout and mid-transaction reset sequences.
module tb_dram_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_write, req_ready, resp_valid;
    logic [N*32-1:0]  req_addr;
    logic [N*128-1:0] req_wdata;
    logic [127:0]     resp_rdata, mem_wdata;
    logic [127:0]     mem_rdata = '0;
    logic             mem_ready = 1'b0;
    logic             mem_valid, mem_write, busy, timeout_err;
    logic [31:0]      mem_adr;

    dram_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DRAM model: one-cycle Ready after each strobe unless muted
    logic [31:0] dram [0:1023];
    bit          loaded = 1'b0;
    bit          dram_mute = 1'b0;
    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (!loaded) begin
            dram[10'h40] <= 32'd1;
            dram[10'h41] <= 32'd2;
            dram[10'h42] <= 32'd3;
            dram[10'h43] <= 32'd4;
            loaded       <= 1'b1;
        end else if (mem_valid && !dram_mute) begin
            mem_ready <= 1'b1;
            if (mem_write) begin
                dram[mem_adr[9:0]]         <= mem_wdata[31:0];
                dram[mem_adr[9:0] + 10'd1] <= mem_wdata[63:32];
                dram[mem_adr[9:0] + 10'd2] <= mem_wdata[95:64];
                dram[mem_adr[9:0] + 10'd3] <= mem_wdata[127:96];
            end else begin
                mem_rdata <= {dram[mem_adr[9:0] + 10'd3], dram[mem_adr[9:0] + 10'd2],
                              dram[mem_adr[9:0] + 10'd1], dram[mem_adr[9:0]]};
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [N-1:0] mask, input logic wr, input logic [31:0] addr,
                             input logic [127:0] wd);
        req_valid = mask;
        req_write = {N{wr}};
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32]    = addr;
            req_wdata[128*i +: 128] = wd;
        end
    endtask

    // Fixed-latency transaction: accept T, strobe T+1, wait T+2, response T+3
    task automatic do_txn(input logic [N-1:0] mask, input logic wr, input logic [31:0] addr,
                          input logic [127:0] wd, input int g, input logic [127:0] rd);
        logic [N-1:0] oh;
        oh = N'(1) << g;
        @(negedge clk);
        drive_req(mask, wr, addr, wd);
        #1;
        chk("req_ready", req_ready, oh);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mem_valid_issue", mem_valid, 1);
        chk("mem_adr", mem_adr, addr & ~32'h3);
        chk("mem_write", mem_write, wr);
        chk("mem_wdata", mem_wdata, wd);
        chk("req_ready_issue", req_ready, 0);
        @(negedge clk);
        #1;
        chk("mem_valid_wait", mem_valid, 0);
        @(negedge clk);
        #1;
        chk("resp_valid", resp_valid, oh);
        chk("resp_rdata", resp_rdata, rd);
        chk("mem_adr_hold", mem_adr, addr & ~32'h3);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wd;
        int           gnt;
        logic [127:0] rd;
    } vec_t;

    localparam logic [127:0] B4321 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] BD    = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] BX    = 128'h11111111_22222222_33333333_44444444;

    vec_t tbl [8];

    initial begin
        int c;
        int last;
        int hit;
        logic err_before;

        tbl[0] = '{4'b0001, 1'b0, 32'h41,  '0, 0, B4321};
        tbl[1] = '{4'b0100, 1'b1, 32'h100, BD, 2, B4321};
        tbl[2] = '{4'b0100, 1'b0, 32'h100, '0, 2, BD};
        tbl[3] = '{4'b0010, 1'b0, 32'h41,  '0, 1, B4321};
        tbl[4] = '{4'b0110, 1'b0, 32'h103, '0, 2, BD};
        tbl[5] = '{4'b1001, 1'b1, 32'h43,  BX, 3, BD};
        tbl[6] = '{4'b1001, 1'b0, 32'h40,  '0, 0, BX};
        tbl[7] = '{4'b1100, 1'b0, 32'h101, '0, 2, BD};

        // Reset state with every requester already pending
        rst_n = 1'b0;
        drive_req(4'hF, 1'b0, 32'h40, '0);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Round-robin under continuous requests
        last = 0;
        for (int k = 0; k < 5; k++) begin
            c = 0;
            while (req_ready == '0 && c < 8) begin
                @(negedge clk);
                #1;
                c++;
            end
            chk("rr_wait_bound", c < 8, 1);
            chk("rr_onehot", $onehot0(req_ready), 1);
            chk("rr_grant", req_ready, N'(1) << (k % N));
            if (k > 0) chk("rr_interval", cyc - last, 4);
            last = cyc;
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            do_txn(tbl[v].mask, tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].gnt, tbl[v].rd);
        end

        // Timeout: DRAM never answers requester 3
        dram_mute = 1'b1;
        @(negedge clk);
        drive_req(4'b1000, 1'b0, 32'h40, '0);
        #1;
        chk("to_req_ready", req_ready, 4'b1000);
        c = 0;
        err_before = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        c = 1;
        while (resp_valid == '0 && c < 40) begin
            @(negedge clk);
            #1;
            c++;
            if (c == TO + 1) err_before = timeout_err;
        end
        chk("to_latency", c, TO + 2);
        chk("to_err_early", err_before, 0);
        chk("to_resp_valid", resp_valid, 4'b1000);
        chk("to_resp_rdata", resp_rdata, 0);
        chk("to_err_set", timeout_err, 1);
        dram_mute = 1'b0;

        do_txn(4'b0010, 1'b0, 32'h40, '0, 1, BX);
        chk("to_err_sticky", timeout_err, 1);

        // Reset while waiting on the DRAM
        dram_mute = 1'b1;
        @(negedge clk);
        drive_req(4'b0100, 1'b0, 32'h100, '0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_mem_valid", mem_valid, 0);
        chk("mid_mem_adr", mem_adr, 0);
        chk("mid_mem_write", mem_write, 0);
        chk("mid_mem_wdata", mem_wdata, 0);
        chk("mid_resp_rdata", resp_rdata, 0);
        chk("mid_timeout_err", timeout_err, 0);
        hit = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (resp_valid != '0) hit++;
        end
        chk("mid_no_resp", hit, 0);
        rst_n = 1'b1;
        dram_mute = 1'b0;
        do_txn(4'b1010, 1'b0, 32'h100, '0, 1, BD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single block-wide DRAM port between NUM_REQ cache controllers.
- Accepts one block read or write from one requester at a time, then drives the DRAM strobe (Valid) for exactly one cycle.
- Waits for DRAM Ready, returns the 128-bit block or a write acknowledgment to the granted requester, and flags DRAM responses that never arrive.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, max cycles in WAIT before a timeout error (>=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request pending; held with fields until req_ready.
- req_write  input  NUM_REQ  1=block write, 0=block read.
- req_addr  input  NUM_REQ*32  word address per requester (slice i = bits 32i+31:32i).
- req_wdata  input  NUM_REQ*128  write block per requester (slice i = bits 128i+127:128i).
- req_ready  output  NUM_REQ  one-hot accept pulse; fields are sampled in this cycle.
- resp_valid  output  NUM_REQ  one-hot completion pulse to the granted requester.
- resp_rdata  output  128  read block; valid when resp_valid is high for a read.
- mem_valid  output  1  DRAM Valid.
- mem_write  output  1  DRAM MemWrite.
- mem_adr  output  32  DRAM DataAdr, block-aligned word address.
- mem_wdata  output  128  DRAM WriteDataBlock.
- mem_rdata  input  128  DRAM ReadDataBlock.
- mem_ready  input  1  DRAM Ready.
- busy  output  1  high in any state except IDLE.
- timeout_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0; grant index 0.
  - All outputs 0, including mem_adr/mem_wdata/resp_rdata.
  - Reset asserted mid-transaction aborts immediately: mem_valid drops asynchronously and no resp_valid is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Combinationally assert req_ready[g].
  - Latch req_write[g], {req_addr[g][31:2],2'b00} and req_wdata[g] into mem_write/mem_adr/mem_wdata.
  - Set rr_ptr=(g+1) mod NUM_REQ and go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE: mem_valid=1 for exactly this cycle; go to WAIT; clear the timeout counter.
- WAIT:
  - mem_valid=0.
  - If mem_ready=1: for a read, register mem_rdata into resp_rdata; for a write, resp_rdata is unchanged. Go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT-1, set timeout_err, load resp_rdata=0, and go to RESP.
- RESP: resp_valid[g]=1 for exactly one cycle; go to IDLE.
- Latency:
  - Accept at cycle T, mem_valid at T+1, mem_ready sampled at T+2, resp_valid at T+3.
  - Next accept at T+4 at the earliest, so peak throughput is one block per 4 cycles.
- mem_adr/mem_write/mem_wdata hold their latched values from ISSUE through RESP and remain stable until the next accept.
- mem_ready is ignored in IDLE, ISSUE and RESP. A stale Ready level from the DRAM never completes a new transaction early.
- req_ready and resp_valid are always one-hot or zero. At most one transaction is outstanding.
- Requester contract:
  - A requester dropping req_valid before req_ready is legal and simply loses arbitration; no state changes.
  - A requester may assert req_valid again in the same cycle its resp_valid fires; it is seen at the following IDLE cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- The address slice uses the full 32 bits; out-of-range handling belongs to the DRAM.

Test Plan:
- Single read: preload DRAM words 0x40..0x43 = 1,2,3,4; req 0 reads addr 0x41. Required:
  - mem_adr=0x40.
  - mem_valid high for exactly 1 cycle.
  - resp_valid[0] at T+3.
  - resp_rdata=0x00000004_00000003_00000002_00000001.
- Write then read: req 2 writes 0xDEADBEEF_CAFEF00D_12345678_9ABCDEF0 to 0x100, then reads 0x100. Required:
  - The write ack arrives with resp_rdata unchanged.
  - The read returns the identical block.
- Round-robin: all 4 requesters hold req_valid from reset. Required:
  - Grant order is 0,1,2,3,0.
  - Accepts occur every 4 cycles.
  - req_ready is never multi-hot.
- Pointer wrap and skip: rr_ptr=3 with only req 1 valid. Required: req 1 is granted and rr_ptr becomes 2.
- Timeout: mem_ready tied to 0 during a req 3 read. Required:
  - timeout_err rises after TIMEOUT cycles in WAIT.
  - resp_valid[3] fires with resp_rdata=0.
  - timeout_err stays high until rst_n goes low.
- Reset mid-op: assert rst_n=0 in WAIT. Required:
  - All outputs are 0 immediately.
  - After release, the first grant goes to the lowest pending requester starting from index 0.
